// File: rtl/ram8.sv
// ram8: 8-word x WIDTH-bit register memory for the Hack memory hierarchy.
// Ports:
//   clk_i      rising-edge clock
//   rst_i      synchronous active-high reset; clears all words and wins over load_i
//   in_i       write data
//   load_i     write enable for word[address_i]
//   address_i  word select for read and write
//   out_o      combinational read of word[address_i] (the old value until the load edge)
module ram8 #(
    parameter int unsigned WIDTH = 16
) (
    input  logic             clk_i,
    input  logic             rst_i,
    input  logic [WIDTH-1:0] in_i,
    input  logic             load_i,
    input  logic [2:0]       address_i,
    output logic [WIDTH-1:0] out_o
);

    localparam int unsigned NWORDS = 8;

    logic [NWORDS-1:0] load_sel;
    logic [WIDTH-1:0]  words [NWORDS];
    logic [WIDTH-1:0]  lvl1  [4];
    logic [WIDTH-1:0]  lvl2  [2];

    // DMux8Way: route load_i to exactly one word
    for (genvar i = 0; i < NWORDS; i++) begin : g_dmux
        assign load_sel[i] = load_i && (address_i == 3'(i));
    end

    // Storage: per bit a hold/load mux feeding a flop
    for (genvar i = 0; i < NWORDS; i++) begin : g_word
        logic [WIDTH-1:0] q;
        logic [WIDTH-1:0] d;

        for (genvar b = 0; b < WIDTH; b++) begin : g_bit
            assign d[b] = load_sel[i] ? in_i[b] : q[b];
        end

        always_ff @(posedge clk_i) begin
            if (rst_i) begin
                q <= '0;
            end else begin
                q <= d;
            end
        end

        assign words[i] = q;
    end

    // Mux8Way: three levels of 2:1 muxes, LSB of the address first
    for (genvar j = 0; j < 4; j++) begin : g_rd_l1
        assign lvl1[j] = address_i[0] ? words[2*j+1] : words[2*j];
    end

    for (genvar j = 0; j < 2; j++) begin : g_rd_l2
        assign lvl2[j] = address_i[1] ? lvl1[2*j+1] : lvl1[2*j];
    end

    assign out_o = address_i[2] ? lvl2[1] : lvl2[0];

endmodule

// File: tb/tb_ram8.sv
// tb_ram8: directed self-checking bench for ram8.
module tb_ram8;

    localparam int unsigned W = 16;

    logic         clk = 1'b0;
    logic         rst;
    logic [W-1:0] din;
    logic         load;
    logic [2:0]   addr;
    logic [W-1:0] dout;

    logic [W-1:0] model [8];

    int passed = 0;
    int total  = 0;

    ram8 #(.WIDTH(W)) dut (
        .clk_i    (clk),
        .rst_i    (rst),
        .in_i     (din),
        .load_i   (load),
        .address_i(addr),
        .out_o    (dout)
    );

    always #5 clk = ~clk;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic check(input string tag, input logic [W-1:0] obs, input logic [W-1:0] exp);
        total++;
        assert (obs === exp) passed++;
        else $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    endtask

    task automatic write_word(input logic [2:0] a, input logic [W-1:0] d);
        addr = a;
        din  = d;
        load = 1'b1;
        tick();
        load = 1'b0;
        model[a] = d;
    endtask

    task automatic do_reset();
        rst = 1'b1;
        tick();
        rst = 1'b0;
        for (int i = 0; i < 8; i++) model[i] = '0;
    endtask

    task automatic check_all(input string tag);
        for (int i = 0; i < 8; i++) begin
            addr = 3'(i);
            #1;
            check($sformatf("%s[%0d]", tag, i), dout, model[i]);
        end
    endtask

    initial begin
        rst  = 1'b0;
        din  = '0;
        load = 1'b0;
        addr = '0;
        #2;

        // Power-up reset
        do_reset();
        check_all("por");

        // Reset clear after preloading all ones
        for (int i = 0; i < 8; i++) write_word(3'(i), 16'hFFFF);
        check_all("preload");
        do_reset();
        check_all("rst_clear");

        // Write/readback per word
        for (int i = 0; i < 8; i++) write_word(3'(i), 16'h1000 + 16'(i));
        check_all("wr_rd");

        // Read during write at the same address: old value until the edge
        write_word(3'd3, 16'h00AA);
        addr = 3'd3;
        din  = 16'h5555;
        load = 1'b1;
        #1;
        check("rdw_before", dout, 16'h00AA);
        tick();
        load = 1'b0;
        model[3] = 16'h5555;
        check("rdw_after", dout, 16'h5555);

        // Address change reads without latency
        addr = 3'd6;
        #1;
        check("rd_addr_change", dout, 16'h1006);

        // Isolation: single write, then noisy inputs with load low
        write_word(3'd5, 16'hBEEF);
        for (int c = 0; c < 10; c++) begin
            din  = 16'($urandom);
            addr = 3'($urandom_range(0, 7));
            tick();
        end
        check_all("isolation");

        // Reset wins over a simultaneous write
        rst  = 1'b1;
        load = 1'b1;
        addr = 3'd2;
        din  = 16'h1234;
        tick();
        rst  = 1'b0;
        load = 1'b0;
        for (int i = 0; i < 8; i++) model[i] = '0;
        addr = 3'd2;
        #1;
        check("collision_w2", dout, 16'h0000);
        check_all("collision");

        // Mid-sequence reset
        for (int i = 0; i < 4; i++) write_word(3'(i), 16'hA000 + 16'(i));
        check_all("mid_pre");
        do_reset();
        write_word(3'd1, 16'h0042);
        addr = 3'd1;
        #1;
        check("mid_w1", dout, 16'h0042);
        check_all("mid_post");

        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end

endmodule
